// File: rtl/div_tick_ctrl.sv
// div_tick_ctrl: programmable divide-by-N tick scheduler.
// Generates a one-cycle tick every N clocks plus a divide-by-2N phase output,
// with glitch-free ratio reprogramming at period boundaries via a shadow register.
// Optional feature macro: TICK_CNT_EN adds a saturating 16-bit tick counter port.
module div_tick_ctrl #(
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned DEF_DIV = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             div_load,
   input  logic [CNT_W-1:0] div_val,
   output logic             div_ack,
   output logic             err,
   output logic             busy,
   output logic             tick,
   output logic             phase,
   output logic [CNT_W-1:0] cnt
`ifdef TICK_CNT_EN
   ,
   output logic [15:0]      tick_cnt
`endif
);

   localparam int unsigned TC_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] active_div, active_nx;
   logic [CNT_W-1:0] shadow, shadow_nx;
   logic             pending, pending_nx;
   logic [CNT_W-1:0] cnt_nx;
   logic             tick_nx, phase_nx, ack_nx, err_nx, busy_nx;
   logic             wrap;
`ifdef TICK_CNT_EN
   logic [TC_W-1:0]  tcnt_nx;
`endif

   // State and registered outputs; synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         active_div <= CNT_W'(DEF_DIV);
         shadow     <= '0;
         pending    <= 1'b0;
         tick       <= 1'b0;
         phase      <= 1'b0;
         div_ack    <= 1'b0;
         err        <= 1'b0;
         busy       <= 1'b0;
`ifdef TICK_CNT_EN
         tick_cnt   <= '0;
`endif
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         active_div <= active_nx;
         shadow     <= shadow_nx;
         pending    <= pending_nx;
         tick       <= tick_nx;
         phase      <= phase_nx;
         div_ack    <= ack_nx;
         err        <= err_nx;
         busy       <= busy_nx;
`ifdef TICK_CNT_EN
         tick_cnt   <= tcnt_nx;
`endif
      end
   end

   // Next-state, counter, ratio shadowing and output decode
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      active_nx  = active_div;
      shadow_nx  = shadow;
      pending_nx = pending;
      tick_nx    = 1'b0;
      phase_nx   = phase;
      ack_nx     = 1'b0;
      err_nx     = 1'b0;
      wrap       = (cnt == (active_div - CNT_W'(1)));

      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (start && !stop) state_nx = RUN;
         end
         RUN, DRAIN: begin
            if (wrap) begin
               cnt_nx   = '0;
               tick_nx  = 1'b1;
               phase_nx = ~phase;
               // only a value captured before this edge is applied here
               if (pending) begin
                  active_nx  = shadow;
                  pending_nx = 1'b0;
                  ack_nx     = 1'b1;
               end
               if (state == DRAIN) state_nx = IDLE;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
            if ((state == RUN) && stop) state_nx = DRAIN;
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase

      // Ratio load: immediate when idle, deferred to next wrap otherwise
      if (div_load) begin
         if (div_val == '0) begin
            err_nx = 1'b1;
         end else if (state == IDLE) begin
            active_nx  = div_val;
            pending_nx = 1'b0;
            ack_nx     = 1'b1;
         end else begin
            shadow_nx  = div_val;
            pending_nx = 1'b1;
         end
      end

      busy_nx = (state_nx != IDLE);
   end

`ifdef TICK_CNT_EN
   // Saturating tick counter, restarted on every IDLE->RUN launch
   always_comb begin
      tcnt_nx = tick_cnt;
      if ((state == IDLE) && (state_nx == RUN)) begin
         tcnt_nx = '0;
      end else if (tick_nx && (tick_cnt != {TC_W{1'b1}})) begin
         tcnt_nx = tick_cnt + TC_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_div_tick_ctrl.sv
// Self-checking bench for div_tick_ctrl: directed scenarios plus randomized
// stimulus compared against a period-position reference model.
module tb_div_tick_ctrl;

   localparam int unsigned CNT_W   = 8;
   localparam int unsigned DEF_DIV = 4;

   logic             clk = 1'b0;
   logic             rst, start, stop, div_load;
   logic [CNT_W-1:0] div_val;
   logic             div_ack, err, busy, tick, phase;
   logic [CNT_W-1:0] cnt;
`ifdef TICK_CNT_EN
   logic [15:0]      tick_cnt;
`endif

   int errors = 0;
   int checks = 0;

   // reference model: running flag, position within the period, ratio bookkeeping
   bit m_run, m_drain, m_pend, m_phase;
   int m_pos, m_div, m_shadow, m_tc;
   bit e_tick, e_ack, e_err;

   div_tick_ctrl #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .stop     (stop),
      .div_load (div_load),
      .div_val  (div_val),
      .div_ack  (div_ack),
      .err      (err),
      .busy     (busy),
      .tick     (tick),
      .phase    (phase),
      .cnt      (cnt)
`ifdef TICK_CNT_EN
      ,
      .tick_cnt (tick_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      bit was_run, was_drain;
      e_tick = 1'b0;
      e_ack  = 1'b0;
      e_err  = 1'b0;
      if (!rst) begin
         m_run = 0; m_drain = 0; m_pos = 0; m_div = DEF_DIV;
         m_pend = 0; m_phase = 0; m_tc = 0;
         return;
      end
      was_run   = m_run;
      was_drain = m_drain;
      if (!was_run) begin
         m_pos = 0;
         if (start && !stop) begin
            m_run = 1; m_drain = 0; m_tc = 0;
         end
      end else begin
         if (m_pos + 1 == m_div) begin
            m_pos   = 0;
            e_tick  = 1'b1;
            m_phase = ~m_phase;
            if (m_tc < 65535) m_tc++;
            if (m_pend) begin
               m_div  = m_shadow;
               m_pend = 0;
               e_ack  = 1'b1;
            end
            if (was_drain) begin
               m_run = 0; m_drain = 0;
            end
         end else begin
            m_pos++;
         end
         if (!was_drain && stop) m_drain = 1;
      end
      if (div_load) begin
         if (int'(div_val) == 0) e_err = 1'b1;
         else if (!was_run) begin
            m_div = int'(div_val); m_pend = 0; e_ack = 1'b1;
         end else begin
            m_shadow = int'(div_val); m_pend = 1;
         end
      end
   endtask

   // one clock: drive on falling edge, step the model at the rising edge, compare after it
   task automatic cycle(input logic r, input logic s, input logic p, input logic l, input int v);
      @(negedge clk);
      rst = r; start = s; stop = p; div_load = l; div_val = CNT_W'(v);
      @(posedge clk);
      model_step();
      #1;
      chk("cnt",   32'(cnt),     32'(m_pos));
      chk("tick",  32'(tick),    32'(e_tick));
      chk("phase", 32'(phase),   32'(m_phase));
      chk("busy",  32'(busy),    32'(m_run));
      chk("ack",   32'(div_ack), 32'(e_ack));
      chk("err",   32'(err),     32'(e_err));
`ifdef TICK_CNT_EN
      chk("tick_cnt", 32'(tick_cnt), 32'(m_tc));
`endif
   endtask

   task automatic to_idle();
      for (int i = 0; i < 300 && m_run; i++) cycle(1, 0, 1, 0, 0);
      chk("to_idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      bit p0;
      rst = 0; start = 0; stop = 0; div_load = 0; div_val = '0;

      // reset defaults and default ratio
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      chk("rst_cnt",   32'(cnt),   32'd0);
      chk("rst_tick",  32'(tick),  32'd0);
      chk("rst_busy",  32'(busy),  32'd0);
      chk("rst_phase", 32'(phase), 32'd0);
      cycle(1, 1, 0, 0, 0);
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_cnt",  32'(cnt),  32'd0);
      for (int i = 1; i <= 8; i++) begin
         cycle(1, 0, 0, 0, 0);
         chk("def_tick", 32'(tick), 32'((i % 4) == 0));
      end
      to_idle();

      // ratio 5 loaded in idle
      cycle(1, 0, 0, 1, 5);
      chk("idle_ack", 32'(div_ack), 32'd1);
      p0 = m_phase;
      cycle(1, 1, 0, 0, 0);
      for (int i = 1; i <= 15; i++) begin
         cycle(1, 0, 0, 0, 0);
         chk("n5_tick",  32'(tick),  32'((i % 5) == 0));
         chk("n5_phase", 32'(phase), 32'(p0 ^ (((i / 5) % 2) == 1)));
      end
`ifdef TICK_CNT_EN
      chk("tc_three", 32'(tick_cnt), 32'd3);
`endif

      // reprogram to 2 mid-period at cnt=1
      cycle(1, 0, 0, 0, 0);
      chk("pre_load_cnt", 32'(cnt), 32'd1);
      cycle(1, 0, 0, 1, 2);
      cycle(1, 0, 0, 0, 0);
      chk("old_ratio_tick", 32'(tick), 32'd0);
      cycle(1, 0, 0, 0, 0);
      chk("old_ratio_tick", 32'(tick), 32'd0);
      cycle(1, 0, 0, 0, 0);
      chk("wrap_tick", 32'(tick),    32'd1);
      chk("wrap_ack",  32'(div_ack), 32'd1);
      for (int i = 1; i <= 6; i++) begin
         cycle(1, 0, 0, 0, 0);
         chk("n2_tick", 32'(tick), 32'((i % 2) == 0));
      end
      to_idle();

      // graceful stop at cnt=2 with N=5
      cycle(1, 0, 0, 1, 5);
      cycle(1, 1, 0, 0, 0);
`ifdef TICK_CNT_EN
      chk("tc_restart", 32'(tick_cnt), 32'd0);
`endif
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      chk("stop_at_cnt", 32'(cnt), 32'd2);
      cycle(1, 0, 1, 0, 0);
      chk("drain_busy", 32'(busy), 32'd1);
      cycle(1, 0, 1, 0, 0);
      chk("drain_busy", 32'(busy), 32'd1);
      cycle(1, 0, 0, 0, 0);
      chk("drain_tick", 32'(tick), 32'd1);
      chk("drain_done", 32'(busy), 32'd0);
      for (int i = 0; i < 6; i++) begin
         cycle(1, 0, 0, 0, 0);
         chk("post_drain_tick", 32'(tick), 32'd0);
      end

      // zero ratio rejected
      cycle(1, 0, 0, 1, 0);
      chk("zero_err", 32'(err),     32'd1);
      chk("zero_ack", 32'(div_ack), 32'd0);

      // N=1
      cycle(1, 0, 0, 1, 1);
      cycle(1, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cycle(1, 0, 0, 0, 0);
         chk("n1_tick", 32'(tick), 32'd1);
         chk("n1_cnt",  32'(cnt),  32'd0);
      end
      to_idle();

      // start and stop together in idle
      cycle(1, 1, 1, 0, 0);
      chk("start_stop_idle", 32'(busy), 32'd0);

      // reset while draining with a pending load
      cycle(1, 0, 0, 1, 6);
      cycle(1, 1, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 1, 3);
      cycle(1, 0, 1, 0, 0);
      cycle(0, 0, 0, 0, 0);
      chk("mid_rst_cnt",   32'(cnt),     32'd0);
      chk("mid_rst_busy",  32'(busy),    32'd0);
      chk("mid_rst_phase", 32'(phase),   32'd0);
      chk("mid_rst_ack",   32'(div_ack), 32'd0);
      cycle(1, 0, 0, 0, 0);
      cycle(1, 1, 0, 0, 0);
      for (int i = 1; i <= 8; i++) begin
         cycle(1, 0, 0, 0, 0);
         chk("post_rst_tick", 32'(tick),    32'((i % 4) == 0));
         chk("post_rst_ack",  32'(div_ack), 32'd0);
      end

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic r, s, p, l;
         r = ($urandom_range(0, 199) != 0);
         s = ($urandom_range(0, 3) == 0);
         p = ($urandom_range(0, 19) == 0);
         l = ($urandom_range(0, 9) == 0);
         cycle(r, s, p, l, int'($urandom_range(0, 6)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
